alu_execute: RTL and testbench

Registered execute stage directly downstream of the ALU operation decoder. Consumes the conditionally inverted operand `ProcessedLow` and the active-low group/refill selects, combines them with the second operand `High` and the carry flag, and produces a registered 16-bit result plus C/Z/N/V flags. It owns the architectural carry flag, so ADC/SBC/RL/RR chain across back-to-back operations, and it applies a valid/ready handshake on both sides.

---
 rtl/alu_execute.sv | 190 +++++++++++++++++++
 tb/tb_alu_execute.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute.sv
// alu_execute: registered 16-bit execute stage with C/Z/N/V flags and a valid/ready handshake.
// Define ALU_EXEC_OVERFLOW_EN to build the V flag register; otherwise FlagV is tied low.
module alu_execute (
   input  logic        clk,
   input  logic        rst,
   input  logic        InValid,
   output logic        InReady,
   input  logic [15:0] High,
   input  logic [15:0] ProcessedLow,
   input  logic        notPAs_ADD,
   input  logic        notPAs_AND,
   input  logic        notPAs_RL,
   input  logic        notPAs_RR,
   input  logic        notRl7,
   input  logic        notRl0,
   input  logic        notRfC,
   input  logic        CinOne,
   input  logic        CinFlag,
   input  logic        FlagsWe,
   input  logic [3:0]  FlagsIn,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [15:0] Result,
   output logic        FlagC,
   output logic        FlagZ,
   output logic        FlagN,
   output logic        FlagV
);

   logic [15:0] result_q, result_d;
   logic        out_valid_q, out_valid_d;
   logic        c_q, c_d;
   logic        z_q, z_d;
   logic        n_q, n_d;

   logic        accept_s;
   logic        cin_s;
   logic        fill_s;
   logic [16:0] sum_s;
   logic [15:0] op_result_s;
   logic        op_c_s;
   logic        op_nop_s;

   // Stall only while holding an unconsumed result; never depends on InValid.
   assign InReady  = ~out_valid_q | OutReady;
   assign accept_s = InValid & InReady;

   assign cin_s = CinOne ? 1'b1 : (CinFlag ? c_q : 1'b0);
   assign sum_s = {1'b0, High} + {1'b0, ProcessedLow} + {16'h0000, cin_s};

   // Shift refill source, highest priority first.
   always_comb begin
      fill_s = 1'b0;
      if (!notRl7) begin
         fill_s = ProcessedLow[15];
      end else if (!notRl0) begin
         fill_s = ProcessedLow[0];
      end else if (!notRfC) begin
         fill_s = c_q;
      end else begin
         fill_s = 1'b0;
      end
   end

   // Group select with ADD > AND > RL > RR priority; no select means a NOP pass.
   always_comb begin
      op_result_s = ProcessedLow;
      op_c_s      = c_q;
      op_nop_s    = 1'b0;
      if (!notPAs_ADD) begin
         op_result_s = sum_s[15:0];
         op_c_s      = sum_s[16];
      end else if (!notPAs_AND) begin
         op_result_s = High & ProcessedLow;
         op_c_s      = 1'b0;
      end else if (!notPAs_RL) begin
         op_result_s = {ProcessedLow[14:0], fill_s};
         op_c_s      = ProcessedLow[15];
      end else if (!notPAs_RR) begin
         op_result_s = {fill_s, ProcessedLow[15:1]};
         op_c_s      = ProcessedLow[0];
      end else begin
         op_result_s = ProcessedLow;
         op_c_s      = c_q;
         op_nop_s    = 1'b1;
      end
   end

   // Next-state for result, handshake and C/Z/N; an accepted op overrides a flag restore.
   always_comb begin
      result_d    = result_q;
      out_valid_d = out_valid_q;
      c_d         = c_q;
      z_d         = z_q;
      n_d         = n_q;
      if (accept_s) begin
         out_valid_d = 1'b1;
         result_d    = op_result_s;
         if (!op_nop_s) begin
            c_d = op_c_s;
            z_d = (op_result_s == 16'h0000);
            n_d = op_result_s[15];
         end else begin
            c_d = c_q;
            z_d = z_q;
            n_d = n_q;
         end
      end else begin
         if (OutReady) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
         if (FlagsWe) begin
            c_d = FlagsIn[3];
            z_d = FlagsIn[2];
            n_d = FlagsIn[1];
         end else begin
            c_d = c_q;
            z_d = z_q;
            n_d = n_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q    <= 16'h0000;
         out_valid_q <= 1'b0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
      end else begin
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         c_q         <= c_d;
         z_q         <= z_d;
         n_q         <= n_d;
      end
   end

   assign OutValid = out_valid_q;
   assign Result   = result_q;
   assign FlagC    = c_q;
   assign FlagZ    = z_q;
   assign FlagN    = n_q;

`ifdef ALU_EXEC_OVERFLOW_EN
   logic v_q, v_d;
   logic add_v_s;

   assign add_v_s = (High[15] == ProcessedLow[15]) && (sum_s[15] != High[15]);

   // Overflow next-state: signed overflow for ADD, cleared by other groups, kept by NOP.
   always_comb begin
      v_d = v_q;
      if (accept_s) begin
         if (!notPAs_ADD) begin
            v_d = add_v_s;
         end else if (!op_nop_s) begin
            v_d = 1'b0;
         end else begin
            v_d = v_q;
         end
      end else if (FlagsWe) begin
         v_d = FlagsIn[0];
      end else begin
         v_d = v_q;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
      end else begin
         v_q <= v_d;
      end
   end

   assign FlagV = v_q;
`else
   logic unused_flags_v_s;

   assign unused_flags_v_s = FlagsIn[0];
   assign FlagV            = 1'b0;
`endif

endmodule

// File: tb/tb_alu_execute.sv
// Directed self-checking bench for alu_execute; expected values are hand-computed.
// V expectations follow ALU_EXEC_OVERFLOW_EN.
module tb_alu_execute;

`ifdef ALU_EXEC_OVERFLOW_EN
   localparam logic VEN = 1'b1;
`else
   localparam logic VEN = 1'b0;
`endif

   // group selects {RR,RL,AND,ADD}, refill selects {Rl7,Rl0,RfC}, all active-low
   localparam logic [3:0] G_ADD  = 4'b1110;
   localparam logic [3:0] G_AND  = 4'b1101;
   localparam logic [3:0] G_RL   = 4'b1011;
   localparam logic [3:0] G_RR   = 4'b0111;
   localparam logic [3:0] G_NONE = 4'b1111;
   localparam logic [2:0] F_NONE = 3'b111;
   localparam logic [2:0] F_RL7  = 3'b011;
   localparam logic [2:0] F_RL0  = 3'b101;
   localparam logic [2:0] F_RFC  = 3'b110;

   logic        clk;
   logic        rst;
   logic        InValid;
   logic        InReady;
   logic [15:0] High;
   logic [15:0] ProcessedLow;
   logic        notPAs_ADD, notPAs_AND, notPAs_RL, notPAs_RR;
   logic        notRl7, notRl0, notRfC;
   logic        CinOne, CinFlag;
   logic        FlagsWe;
   logic [3:0]  FlagsIn;
   logic        OutValid;
   logic        OutReady;
   logic [15:0] Result;
   logic        FlagC, FlagZ, FlagN, FlagV;

   int pass_cnt;
   int total_cnt;

   alu_execute dut (
      .clk          (clk),
      .rst          (rst),
      .InValid      (InValid),
      .InReady      (InReady),
      .High         (High),
      .ProcessedLow (ProcessedLow),
      .notPAs_ADD   (notPAs_ADD),
      .notPAs_AND   (notPAs_AND),
      .notPAs_RL    (notPAs_RL),
      .notPAs_RR    (notPAs_RR),
      .notRl7       (notRl7),
      .notRl0       (notRl0),
      .notRfC       (notRfC),
      .CinOne       (CinOne),
      .CinFlag      (CinFlag),
      .FlagsWe      (FlagsWe),
      .FlagsIn      (FlagsIn),
      .OutValid     (OutValid),
      .OutReady     (OutReady),
      .Result       (Result),
      .FlagC        (FlagC),
      .FlagZ        (FlagZ),
      .FlagN        (FlagN),
      .FlagV        (FlagV)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic [3:0] exp);
      check(tag, {28'h0, FlagC, FlagZ, FlagN, FlagV}, {28'h0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [15:0] hi, input logic [15:0] lo, input logic [3:0] grp_n,
                           input logic [2:0] fill_n, input logic cin_one, input logic cin_flag);
      InValid      = 1'b1;
      High         = hi;
      ProcessedLow = lo;
      {notPAs_RR, notPAs_RL, notPAs_AND, notPAs_ADD} = grp_n;
      {notRl7, notRl0, notRfC} = fill_n;
      CinOne       = cin_one;
      CinFlag      = cin_flag;
   endtask

   task automatic run_op(input logic [15:0] hi, input logic [15:0] lo, input logic [3:0] grp_n,
                         input logic [2:0] fill_n, input logic cin_one, input logic cin_flag);
      drive_op(hi, lo, grp_n, fill_n, cin_one, cin_flag);
      tick();
      InValid = 1'b0;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst       = 1'b1;
      InValid   = 1'b0;
      OutReady  = 1'b1;
      FlagsWe   = 1'b0;
      FlagsIn   = 4'b0000;
      drive_op(16'h0000, 16'h0000, G_NONE, F_NONE, 1'b0, 1'b0);
      InValid   = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_outvalid", OutValid, 1'b0);
      check("rst_result", Result, 16'h0000);
      check_flags("rst_flags", 4'b0000);
      OutReady = 1'b0;
      #1;
      check("rst_inready", InReady, 1'b1);
      OutReady = 1'b1;

      run_op(16'hFFFF, 16'h0001, G_ADD, F_NONE, 1'b0, 1'b0);
      check("add_wrap_res", Result, 16'h0000);
      check("add_wrap_valid", OutValid, 1'b1);
      check_flags("add_wrap_flags", 4'b1100);

      run_op(16'h0001, 16'h0001, G_ADD, F_NONE, 1'b0, 1'b1);
      check("adc_res", Result, 16'h0003);
      check_flags("adc_flags", 4'b0000);

      run_op(16'h0005, 16'hFFF8, G_ADD, F_NONE, 1'b1, 1'b0);
      check("sub_res", Result, 16'hFFFE);
      check_flags("sub_flags", 4'b0010);

      run_op(16'h0000, 16'h8001, G_RL, F_RL7, 1'b0, 1'b0);
      check("rlc_res", Result, 16'h0003);
      check_flags("rlc_flags", 4'b1000);

      run_op(16'h0000, 16'h8002, G_RR, F_RL7, 1'b0, 1'b0);
      check("sra_res", Result, 16'hC001);
      check_flags("sra_flags", 4'b0010);

      run_op(16'h0000, 16'h8000, G_RL, F_NONE, 1'b0, 1'b0);
      check("rl_res", Result, 16'h0000);
      check_flags("rl_flags", 4'b1100);

      run_op(16'h0000, 16'h1234, G_NONE, F_NONE, 1'b0, 1'b0);
      check("nop_res", Result, 16'h1234);
      check_flags("nop_flags", 4'b1100);

      run_op(16'h0000, 16'h0002, G_RR, F_RFC, 1'b0, 1'b0);
      check("rr_c_res", Result, 16'h8001);
      check_flags("rr_c_flags", 4'b0010);

      run_op(16'h0000, 16'h0001, G_RL, F_RL0, 1'b0, 1'b0);
      check("rl0_res", Result, 16'h0003);
      check_flags("rl0_flags", 4'b0000);

      run_op(16'hF0F0, 16'h3C3C, G_AND, F_NONE, 1'b0, 1'b0);
      check("and_res", Result, 16'h3030);

      run_op(16'h00FF, 16'h0F0F, 4'b1100, F_NONE, 1'b0, 1'b0);
      check("prio_add_res", Result, 16'h100E);

      run_op(16'h7FFF, 16'h0001, G_ADD, F_NONE, 1'b0, 1'b0);
      check("ovf_res", Result, 16'h8000);
      check_flags("ovf_flags", {3'b001, VEN});

      run_op(16'h0000, 16'h0000, G_ADD, F_NONE, 1'b1, 1'b1);
      check("cinone_wins", Result, 16'h0001);
      check_flags("cinone_flags", 4'b0000);

      FlagsWe = 1'b1;
      FlagsIn = 4'b1111;
      run_op(16'h0001, 16'h0001, G_ADD, F_NONE, 1'b0, 1'b0);
      FlagsWe = 1'b0;
      check("we_ignored_res", Result, 16'h0002);
      check_flags("we_ignored_flags", 4'b0000);

      tick();
      check("drain_valid", OutValid, 1'b0);

      // Backpressure: hold the first result while the next op waits.
      OutReady = 1'b0;
      drive_op(16'h0001, 16'h0002, G_ADD, F_NONE, 1'b0, 1'b0);
      tick();
      drive_op(16'h0010, 16'h0020, G_ADD, F_NONE, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("bp_inready", InReady, 1'b0);
         check("bp_valid", OutValid, 1'b1);
         check("bp_result", Result, 16'h0003);
         tick();
      end
      OutReady = 1'b1;
      #1;
      check("bp_release_inready", InReady, 1'b1);
      tick();
      check("bp_next_res", Result, 16'h0030);
      check("bp_next_valid", OutValid, 1'b1);
      drive_op(16'h0040, 16'h0001, G_ADD, F_NONE, 1'b0, 1'b0);
      tick();
      check("stream_res", Result, 16'h0041);
      check("stream_valid", OutValid, 1'b1);
      InValid = 1'b0;
      tick();
      check("stream_drain", OutValid, 1'b0);

      // Reset while a result is pending and C is set.
      OutReady = 1'b0;
      run_op(16'hFFFF, 16'h0001, G_ADD, F_NONE, 1'b0, 1'b0);
      check("pre_rst_valid", OutValid, 1'b1);
      check("pre_rst_c", FlagC, 1'b1);
      rst = 1'b1;
      drive_op(16'h1111, 16'h2222, G_ADD, F_NONE, 1'b0, 1'b0);
      tick();
      rst     = 1'b0;
      InValid = 1'b0;
      check("mid_rst_valid", OutValid, 1'b0);
      check("mid_rst_result", Result, 16'h0000);
      check_flags("mid_rst_flags", 4'b0000);
      check("mid_rst_inready", InReady, 1'b1);

      FlagsWe = 1'b1;
      FlagsIn = 4'b1000;
      tick();
      check_flags("restore_c", 4'b1000);
      check("restore_valid", OutValid, 1'b0);
      check("restore_result", Result, 16'h0000);
      FlagsIn = 4'b0001;
      tick();
      FlagsWe = 1'b0;
      check_flags("restore_v", {3'b000, VEN});

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
